alu_seq: RTL and testbench

Parametrised, clocked successor to the 8-bit combinational ALU. It registers operands and results and runs a START/DONE handshake. It adds variable-distance iterative shifts and an optional shift-add multiplier, and produces registered C/V/N/Z flags. It sits between the operand/opcode source and the datapath consumers; the seven-segment drivers stay outside and read Y.

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_addsub.sv | 33 +++
 rtl/alu_seq.sv | 208 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module : alu_seq_pkg                                                        |
// | Desc   : Opcodes, FSM state encoding and flag bundle for alu_seq.           |
// |          Macro ALU_SEQ_MUL_EN selects OP_MUL (defined) or OP_XOR for 3'b111. |
// | Rev    : 1.0 - initial release                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

package alu_seq_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ADD = 3'b000;
  localparam opcode_t OP_SUB = 3'b001;
  localparam opcode_t OP_AND = 3'b010;
  localparam opcode_t OP_OR  = 3'b011;
  localparam opcode_t OP_SLL = 3'b100;
  localparam opcode_t OP_SRL = 3'b101;
  localparam opcode_t OP_SRA = 3'b110;
`ifdef ALU_SEQ_MUL_EN
  localparam opcode_t OP_MUL = 3'b111;
`else
  localparam opcode_t OP_XOR = 3'b111;
`endif

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_EXEC = 1'b1;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;

endpackage

`default_nettype wire

// File: rtl/alu_addsub.sv
// +-----------------------------------------------------------------------------+
// | Module : alu_addsub                                                         |
// | Desc   : Combinational WIDTH-bit adder/subtractor with carry-in, C and V.   |
// | Rev    : 1.0 - initial release                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module alu_addsub
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_c,
  output logic             o_v
);

  logic [WIDTH-1:0] w_b;

  assign w_b = i_sub ? ~i_b : i_b;

  assign {o_c, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_cin};

  // Overflow: operands of equal sign producing a result of the other sign.
  assign o_v = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// +-----------------------------------------------------------------------------+
// | Module : alu_seq                                                            |
// | Desc   : Sequential ALU with START/DONE handshake, iterative shifts and     |
// |          optional shift-add multiplier (macro ALU_SEQ_MUL_EN).              |
// | Rev    : 1.0 - initial release                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z
);

  localparam int SHW = $clog2(WIDTH);

  state_t           r_state;
  opcode_t          r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic [SHW-1:0]   r_cnt;
  logic             r_sc;
  logic             r_done;
  flags_t           r_flags;

  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_add_c;
  logic             w_add_v;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_sh_out;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_last;
  flags_t           w_flags;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] r_hi;
  logic             w_is_mul;
  logic [WIDTH:0]   w_mul_ext;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;

  // The multiplier low half lives in r_b and is consumed LSB first.
  assign w_is_mul  = (r_op == OP_MUL);
  assign w_add_a   = w_is_mul ? r_hi : r_a;
  assign w_add_b   = w_is_mul ? r_a  : r_b;
  assign w_mul_ext = r_b[0] ? {w_add_c, w_sum} : {1'b0, r_hi};
  assign w_mul_hi  = w_mul_ext[WIDTH:1];
  assign w_mul_lo  = {w_mul_ext[0], r_b[WIDTH-1:1]};
`else
  assign w_add_a = r_a;
  assign w_add_b = r_b;
`endif

  assign w_sub = (r_op == OP_SUB);

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_sub (w_sub),
    .i_cin (w_sub),
    .o_sum (w_sum),
    .o_c   (w_add_c),
    .o_v   (w_add_v)
  );

  always_comb begin
    w_sh_next = r_a;
    w_sh_out  = 1'b0;
    case (r_op)
      OP_SLL: begin
        w_sh_next = {r_a[WIDTH-2:0], 1'b0};
        w_sh_out  = r_a[WIDTH-1];
      end
      OP_SRL: begin
        w_sh_next = {1'b0, r_a[WIDTH-1:1]};
        w_sh_out  = r_a[0];
      end
      OP_SRA: begin
        w_sh_next = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
        w_sh_out  = r_a[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_res  = r_a;
    w_c    = 1'b0;
    w_v    = 1'b0;
    w_last = 1'b1;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_res = w_sum;
        w_c   = w_add_c;
        w_v   = w_add_v;
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_SLL, OP_SRL, OP_SRA: begin
        w_res  = r_a;
        w_c    = r_sc;
        w_last = (r_cnt == '0);
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        w_res  = w_mul_lo;
        w_c    = |w_mul_hi;
        w_v    = |w_mul_hi;
        w_last = (r_cnt == '0);
      end
`else
      OP_XOR: w_res = r_a ^ r_b;
`endif
      default: ;
    endcase
  end

  assign w_flags = '{c: w_c, v: w_v, n: w_res[WIDTH-1], z: (w_res == '0)};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_sc    <= 1'b0;
      r_done  <= 1'b0;
      r_flags <= '0;
`ifdef ALU_SEQ_MUL_EN
      r_hi    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_op    <= OP;
            r_a     <= A;
            r_b     <= B;
            r_sc    <= 1'b0;
            r_state <= ST_EXEC;
`ifdef ALU_SEQ_MUL_EN
            r_hi    <= '0;
            r_cnt   <= (OP == OP_MUL) ? SHW'(WIDTH - 1) : B[SHW-1:0];
`else
            r_cnt   <= B[SHW-1:0];
`endif
          end
        end
        ST_EXEC: begin
          // The final multiply step is folded into the completion edge.
          if (w_last) begin
            r_y     <= w_res;
            r_flags <= w_flags;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - SHW'(1);
            r_a   <= w_sh_next;
            r_sc  <= w_sh_out;
`ifdef ALU_SEQ_MUL_EN
            if (w_is_mul) begin
              r_hi <= w_mul_hi;
              r_b  <= w_mul_lo;
            end
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY = (r_state == ST_EXEC);
  assign DONE = r_done;
  assign Y    = r_y;
  assign C    = r_flags.c;
  assign V    = r_flags.v;
  assign N    = r_flags.n;
  assign Z    = r_flags.z;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// +-----------------------------------------------------------------------------+
// | Module : tb_alu_seq                                                         |
// | Desc   : Directed self-checking bench for alu_seq (WIDTH=8); honours         |
// |          ALU_SEQ_MUL_EN for opcode 111 expectations.                        |
// | Rev    : 1.0 - initial release                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_seq;

  localparam logic [2:0] T_ADD = 3'b000;
  localparam logic [2:0] T_SUB = 3'b001;
  localparam logic [2:0] T_AND = 3'b010;
  localparam logic [2:0] T_OR  = 3'b011;
  localparam logic [2:0] T_SLL = 3'b100;
  localparam logic [2:0] T_SRL = 3'b101;
  localparam logic [2:0] T_SRA = 3'b110;
  localparam logic [2:0] T_OP7 = 3'b111;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [2:0] OP    = 3'b000;
  logic [7:0] A     = 8'h00;
  logic [7:0] B     = 8'h00;
  logic       BUSY;
  logic       DONE;
  logic [7:0] Y;
  logic       C;
  logic       V;
  logic       N;
  logic       Z;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic [3:0] cvnz;
    int         lat;
    string      nm;
  } vec_t;

  always #5 CLK = ~CLK;

  alu_seq #(.WIDTH(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .OP    (OP),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .Y     (Y),
    .C     (C),
    .V     (V),
    .N     (N),
    .Z     (Z)
  );

  // Issues one op and returns the number of edges from acceptance to DONE (-1 on timeout).
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic busy_e);
    @(negedge CLK);
    START = 1'b1; OP = op; A = a; B = b;
    @(posedge CLK); #1;
    busy_e = BUSY;
    START = 1'b0; A = ~a; B = ~b;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if ({Y, C, V, N, Z, BUSY, DONE} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_state: got Y=%h CVNZ=%b%b%b%b BUSY=%b DONE=%b want all zero",
               Y, C, V, N, Z, BUSY, DONE);
    end
    // START presented together with reset release must be taken on the very next edge.
    @(negedge CLK);
    RESET = 1'b0; START = 1'b1; OP = T_ADD; A = 8'h03; B = 8'h04;
    @(posedge CLK); #1;
    START = 1'b0;
    n_cmp++;
    if (BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL first_start_busy: got %b want 1", BUSY);
    end
    @(posedge CLK); #1;
    n_cmp++;
    if ({DONE, Y} !== {1'b1, 8'h07}) begin
      n_bad++;
      $display("FAIL first_start_done: got DONE=%b Y=%h want DONE=1 Y=07", DONE, Y);
    end
  endtask

  task automatic test_alu_ops();
    vec_t vecs[$];
    int   lat;
    logic busy_e;
    vecs.push_back('{T_ADD, 8'h7F, 8'h01, 8'h80, 4'b0110, 1, "add_ovf"});
    vecs.push_back('{T_SUB, 8'h05, 8'h05, 8'h00, 4'b1001, 1, "sub_zero"});
    vecs.push_back('{T_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1, "and"});
    vecs.push_back('{T_OR,  8'h0F, 8'h30, 8'h3F, 4'b0000, 1, "or"});
    vecs.push_back('{T_SRA, 8'h90, 8'h03, 8'hF2, 4'b0010, 4, "sra3"});
    vecs.push_back('{T_SLL, 8'h81, 8'h01, 8'h02, 4'b1000, 2, "sll1"});
    vecs.push_back('{T_SRL, 8'hA5, 8'h08, 8'hA5, 4'b0010, 1, "srl_amt0"});
    vecs.push_back('{T_SRA, 8'h83, 8'h02, 8'hE0, 4'b1010, 3, "sra2_carry"});
    vecs.push_back('{T_SLL, 8'h40, 8'hF9, 8'h80, 4'b0010, 2, "sll_upper_b"});
`ifdef ALU_SEQ_MUL_EN
    vecs.push_back('{T_OP7, 8'h10, 8'h10, 8'h00, 4'b1101, 8, "mul_ovf"});
    vecs.push_back('{T_OP7, 8'h0F, 8'h03, 8'h2D, 4'b0000, 8, "mul_small"});
`else
    vecs.push_back('{T_OP7, 8'h10, 8'h10, 8'h00, 4'b0001, 1, "xor_zero"});
    vecs.push_back('{T_OP7, 8'h5A, 8'h0F, 8'h55, 4'b0000, 1, "xor"});
`endif
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_e);
      n_cmp++;
      if (busy_e !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_busy: got %b want 1", vecs[i].nm, busy_e);
      end
      n_cmp++;
      if (lat != vecs[i].lat) begin
        n_bad++;
        $display("FAIL %s_latency: got %0d want %0d", vecs[i].nm, lat, vecs[i].lat);
      end
      n_cmp++;
      if ({Y, C, V, N, Z} !== {vecs[i].y, vecs[i].cvnz}) begin
        n_bad++;
        $display("FAIL %s_result: got Y=%h CVNZ=%b%b%b%b want Y=%h CVNZ=%b",
                 vecs[i].nm, Y, C, V, N, Z, vecs[i].y, vecs[i].cvnz);
      end
    end
  endtask

  task automatic test_done_pulse();
    int   lat;
    logic busy_e;
    run_op(T_ADD, 8'h01, 8'h01, lat, busy_e);
    n_cmp++;
    if ({lat == 1, BUSY} !== 2'b10) begin
      n_bad++;
      $display("FAIL done_cycle: got lat=%0d BUSY=%b want lat=1 BUSY=0", lat, BUSY);
    end
    @(posedge CLK); #1;
    n_cmp++;
    if ({DONE, BUSY, Y} !== {2'b00, 8'h02}) begin
      n_bad++;
      $display("FAIL done_pulse_hold: got DONE=%b BUSY=%b Y=%h want DONE=0 BUSY=0 Y=02",
               DONE, BUSY, Y);
    end
  endtask

  task automatic test_start_ignored();
    int n_done = 0;
    int first  = -1;
    @(negedge CLK);
    START = 1'b1; OP = T_SRL; A = 8'hFF; B = 8'h07;
    @(posedge CLK); #1;
    for (int n = 1; n <= 16; n++) begin
      if (n <= 7) begin
        @(negedge CLK);
        START = 1'b1; OP = T_ADD; A = 8'(n); B = 8'(n);
      end else begin
        START = 1'b0;
      end
      @(posedge CLK); #1;
      if (DONE === 1'b1) begin
        n_done++;
        if (first < 0) first = n;
      end
    end
    START = 1'b0;
    n_cmp++;
    if (n_done != 1 || first != 8) begin
      n_bad++;
      $display("FAIL start_ignored_done: got %0d DONE(s) first at %0d want 1 at 8", n_done, first);
    end
    n_cmp++;
    if ({Y, C, V, N, Z} !== {8'h01, 4'b1000}) begin
      n_bad++;
      $display("FAIL start_ignored_result: got Y=%h CVNZ=%b%b%b%b want Y=01 CVNZ=1000",
               Y, C, V, N, Z);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic busy_e;
    run_op(T_ADD, 8'h01, 8'h02, lat, busy_e);
    n_cmp++;
    if (lat != 1 || Y !== 8'h03) begin
      n_bad++;
      $display("FAIL b2b_first: got lat=%0d Y=%h want lat=1 Y=03", lat, Y);
    end
    // New request raised inside the DONE cycle.
    START = 1'b1; OP = T_ADD; A = 8'h10; B = 8'h20;
    @(posedge CLK); #1;
    START = 1'b0; A = 8'hFF; B = 8'hFF;
    n_cmp++;
    if ({DONE, BUSY} !== 2'b01) begin
      n_bad++;
      $display("FAIL b2b_accept: got DONE=%b BUSY=%b want DONE=0 BUSY=1", DONE, BUSY);
    end
    @(posedge CLK); #1;
    n_cmp++;
    if ({DONE, Y} !== {1'b1, 8'h30}) begin
      n_bad++;
      $display("FAIL b2b_second: got DONE=%b Y=%h want DONE=1 Y=30", DONE, Y);
    end
  endtask

  task automatic test_reset_mid_op();
    int   lat;
    logic busy_e;
    int   n_done = 0;
    @(negedge CLK);
`ifdef ALU_SEQ_MUL_EN
    START = 1'b1; OP = T_OP7; A = 8'h0F; B = 8'h03;
`else
    START = 1'b1; OP = T_SLL; A = 8'h01; B = 8'h07;
`endif
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    n_cmp++;
    if ({Y, C, V, N, Z, BUSY, DONE} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_mid_clear: got Y=%h CVNZ=%b%b%b%b BUSY=%b DONE=%b want all zero",
               Y, C, V, N, Z, BUSY, DONE);
    end
    @(negedge CLK);
    RESET = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) n_done++;
    end
    n_cmp++;
    if (n_done != 0) begin
      n_bad++;
      $display("FAIL reset_mid_no_done: got %0d DONE(s) want 0", n_done);
    end
    run_op(T_ADD, 8'h22, 8'h11, lat, busy_e);
    n_cmp++;
    if (lat != 1 || {Y, C, V, N, Z} !== {8'h33, 4'b0000}) begin
      n_bad++;
      $display("FAIL reset_mid_recover: got lat=%0d Y=%h CVNZ=%b%b%b%b want lat=1 Y=33 CVNZ=0000",
               lat, Y, C, V, N, Z);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_done_pulse();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
